// File: rtl/pio_bidir_edge.sv
// pio_bidir_edge: Avalon-MM slave general-purpose I/O port.
//
// Configurable-width PIO with per-bit direction, optional open-drain drive,
// atomic set/clear of the output register, synchronised input readback,
// edge capture and a level interrupt gated by a per-bit mask.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   chipselect_i      slave select
//   address_i [2:0]   register index (DATA, DIRECTION, IRQMASK, EDGECAPTURE,
//                     OUTSET, OUTCLEAR, 2 reserved)
//   write_n_i         active-low write strobe
//   writedata_i[31:0] write data, bits above DATA_WIDTH ignored
//   readdata_o[31:0]  combinational read data, zero-extended
//   pad_in_i          asynchronous pad inputs
//   pad_out_o         pad output values
//   pad_oe_o          pad output enables, 1 = drive
//   irq_o             registered level interrupt, active high
module pio_bidir_edge #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    OPEN_DRAIN  = 0,
  parameter int                    EDGE_TYPE   = 0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect_i,
  input  logic [2:0]            address_i,
  input  logic                  write_n_i,
  input  logic [31:0]           writedata_i,
  output logic [31:0]           readdata_o,
  input  logic [DATA_WIDTH-1:0] pad_in_i,
  output logic [DATA_WIDTH-1:0] pad_out_o,
  output logic [DATA_WIDTH-1:0] pad_oe_o,
  output logic                  irq_o
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_chain_q;
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [2:0]            warm_q, warm_d;
  logic                  irq_q, irq_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] edge_raw;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_wdata;

  assign wr_en  = chipselect_i & ~write_n_i;
  assign wdata  = writedata_i[DATA_WIDTH-1:0];
  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  // Upper write-data bits are deliberately discarded when DATA_WIDTH < 32.
  assign unused_wdata = ^writedata_i;

  always_comb begin
    unique case (EDGE_TYPE)
      0:       edge_raw = sync_q & ~prev_q;
      1:       edge_raw = ~sync_q & prev_q;
      default: edge_raw = sync_q ^ prev_q;
    endcase
    // Until the synchroniser and prev_q hold real pad samples, the
    // reset-zero history would look like edges on pads held high.
    edge_det = (warm_q == WARM_MAX) ? edge_raw : '0;
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    edgecap_d  = edgecap_q;
    warm_d     = (warm_q == WARM_MAX) ? warm_q : warm_q + 3'd1;
    if (wr_en) begin
      unique case (address_i)
        A_DATA:   data_out_d = wdata;
        A_DIR:    dir_d      = wdata;
        A_MASK:   mask_d     = wdata;
        A_EDGE:   edgecap_d  = edgecap_q & ~wdata;
        A_OUTSET: data_out_d = data_out_q | wdata;
        A_OUTCLR: data_out_d = data_out_q & ~wdata;
        default:  ;
      endcase
    end
    // Applied after the clear so a coincident new edge keeps the bit set.
    edgecap_d = edgecap_d | edge_det;
    irq_d     = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= RESET_VALUE;
      dir_q        <= '0;
      mask_q       <= '0;
      edgecap_q    <= '0;
      sync_chain_q <= '0;
      prev_q       <= '0;
      warm_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      mask_q       <= mask_d;
      edgecap_q    <= edgecap_d;
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], pad_in_i};
      prev_q       <= sync_q;
      warm_q       <= warm_d;
      irq_q        <= irq_d;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (address_i)
      A_DATA:  rd_val = sync_q;
      A_DIR:   rd_val = dir_q;
      A_MASK:  rd_val = mask_q;
      A_EDGE:  rd_val = edgecap_q;
      default: rd_val = '0;
    endcase
    readdata_o                 = '0;
    readdata_o[DATA_WIDTH-1:0] = rd_val;
  end

  generate
    if (OPEN_DRAIN != 0) begin : g_od
      // Released bits float to the external pull-up.
      assign pad_out_o = '0;
      assign pad_oe_o  = dir_q & ~data_out_q;
    end else begin : g_pp
      assign pad_out_o = data_out_q;
      assign pad_oe_o  = dir_q;
    end
  endgenerate

  assign irq_o = irq_q;

endmodule

// File: tb/tb_pio_bidir_edge.sv
module tb_pio_bidir_edge;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs0, cs1;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd0, rd1;
  logic [7:0]  pad_in;
  logic [7:0]  pout0, poe0, pout1, poe1;
  logic        irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_bidir_edge #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .OPEN_DRAIN(0),
                   .EDGE_TYPE(0), .SYNC_STAGES(N)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect_i(cs0), .address_i(address),
    .write_n_i(write_n), .writedata_i(writedata), .readdata_o(rd0),
    .pad_in_i(pad_in), .pad_out_o(pout0), .pad_oe_o(poe0), .irq_o(irq0));

  pio_bidir_edge #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .OPEN_DRAIN(1),
                   .EDGE_TYPE(0), .SYNC_STAGES(N)) dut_od (
    .clk(clk), .reset_n(reset_n), .chipselect_i(cs1), .address_i(address),
    .write_n_i(write_n), .writedata_i(writedata), .readdata_o(rd1),
    .pad_in_i(pad_in), .pad_out_o(pout1), .pad_oe_o(poe1), .irq_o(irq1));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    cs0 = (sel == 1'b0);
    cs1 = (sel == 1'b1);
    address = a; writedata = d; write_n = 1'b0;
    tick(1);
    cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, output logic [31:0] v);
    cs0 = (sel == 1'b0);
    cs1 = (sel == 1'b1);
    address = a; write_n = 1'b1;
    #1;
    v = sel ? rd1 : rd0;
    cs0 = 1'b0; cs1 = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset_n = 1'b0; pad_in = 8'h3C;
    cs0 = 0; cs1 = 0; address = 0; write_n = 1; writedata = 0;
    tick(3);
    n_checks++;
    if (pout0 !== 8'hA5) begin n_fail++; $display("FAIL reset_pad_out got %h exp a5", pout0); end
    n_checks++;
    if (poe0 !== 8'h00) begin n_fail++; $display("FAIL reset_pad_oe got %h exp 00", poe0); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq0); end
    #3 reset_n = 1'b1;
    tick(N + 1);
    rd(0, 3'd0, v);
    n_checks++;
    if (v !== 32'h3C) begin n_fail++; $display("FAIL reset_readback got %h exp 3c", v); end
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_edgecap got %h exp 0", v); end
  endtask

  task automatic test_set_clear;
    logic [31:0] v;
    wr(0, 3'd1, 32'hFF);
    n_checks++;
    if (poe0 !== 8'hFF) begin n_fail++; $display("FAIL dir_oe got %h exp ff", poe0); end
    wr(0, 3'd0, 32'h0F);
    n_checks++;
    if (pout0 !== 8'h0F) begin n_fail++; $display("FAIL data_write got %h exp 0f", pout0); end
    wr(0, 3'd4, 32'h30);
    n_checks++;
    if (pout0 !== 8'h3F) begin n_fail++; $display("FAIL outset got %h exp 3f", pout0); end
    wr(0, 3'd5, 32'h01);
    n_checks++;
    if (pout0 !== 8'h3E) begin n_fail++; $display("FAIL outclear got %h exp 3e", pout0); end
    rd(0, 3'd4, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL read_outset got %h exp 0", v); end
    rd(0, 3'd5, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL read_outclear got %h exp 0", v); end
    wr(0, 3'd6, 32'hFF);
    rd(0, 3'd6, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL read_reserved got %h exp 0", v); end
    wr(0, 3'd2, 32'h1234_5600);
    rd(0, 3'd2, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL wide_write got %h exp 0", v); end
    wr(0, 3'd2, 32'hFFFF_FF81);
    rd(0, 3'd2, v);
    n_checks++;
    if (v !== 32'h81) begin n_fail++; $display("FAIL mask_readback got %h exp 81", v); end
    n_checks++;
    if (pout0 !== 8'h3E) begin n_fail++; $display("FAIL reserved_side_effect got %h exp 3e", pout0); end
  endtask

  task automatic test_open_drain;
    wr(1, 3'd1, 32'h01);
    wr(1, 3'd0, 32'h00);
    n_checks++;
    if (poe1 !== 8'h01) begin n_fail++; $display("FAIL od_low_oe got %h exp 01", poe1); end
    n_checks++;
    if (pout1 !== 8'h00) begin n_fail++; $display("FAIL od_low_out got %h exp 00", pout1); end
    wr(1, 3'd0, 32'h01);
    n_checks++;
    if (poe1 !== 8'h00) begin n_fail++; $display("FAIL od_release_oe got %h exp 00", poe1); end
  endtask

  task automatic test_edge_irq;
    logic [31:0] v;
    pad_in = 8'h38;
    tick(N + 3);
    wr(0, 3'd3, 32'hFF);
    wr(0, 3'd2, 32'h04);
    tick(1);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL edge_irq_idle got %b exp 0", irq0); end
    pad_in = 8'h3C;
    tick(N);
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL edge_early got %h exp 0", v); end
    tick(1);
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h04) begin n_fail++; $display("FAIL edge_capture got %h exp 04", v); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq0); end
    tick(1);
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b exp 1", irq0); end
    wr(0, 3'd3, 32'h04);
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL edge_clear got %h exp 0", v); end
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b exp 1", irq0); end
    tick(1);
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_deassert got %b exp 0", irq0); end
  endtask

  task automatic test_collision;
    logic [31:0] v;
    pad_in = 8'h38;
    tick(N + 2);
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL fall_ignored got %h exp 0", v); end
    pad_in = 8'h3C;
    tick(N);
    wr(0, 3'd3, 32'h04);
    rd(0, 3'd3, v);
    n_checks++;
    if (v !== 32'h04) begin n_fail++; $display("FAIL collision got %h exp 04", v); end
    tick(1);
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL collision_irq got %b exp 1", irq0); end
  endtask

  task automatic test_warmup;
    logic [31:0] v;
    #3;
    pad_in  = 8'hFF;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pout0 !== 8'hA5) begin n_fail++; $display("FAIL async_pad_out got %h exp a5", pout0); end
    n_checks++;
    if (poe0 !== 8'h00) begin n_fail++; $display("FAIL async_pad_oe got %h exp 00", poe0); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL async_irq got %b exp 0", irq0); end
    tick(3);
    #3 reset_n = 1'b1;
    tick(1);
    wr(0, 3'd2, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      rd(0, 3'd3, v);
      n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL warmup_cap[%0d] got %h exp 0", i, v); end
      n_checks++;
      if (irq0 !== 1'b0) begin n_fail++; $display("FAIL warmup_irq[%0d] got %b exp 0", i, irq0); end
      tick(1);
    end
    rd(0, 3'd0, v);
    n_checks++;
    if (v !== 32'hFF) begin n_fail++; $display("FAIL warmup_readback got %h exp ff", v); end
  endtask

  initial begin
    test_reset;
    test_set_clear;
    test_open_drain;
    test_edge_irq;
    test_collision;
    test_warmup;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
